// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpu_pkg                                                |
// | Description : Shared definitions for the multi-cycle CPU sequencer:  |
// |               stage state encoding and inter-stage bus widths.       |
// | Ports       : none (package)                                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package cpu_pkg;

   localparam int ID_EXE_W  = 150;
   localparam int EXE_MEM_W = 106;

   localparam int c_state_w = 3;
   typedef logic [c_state_w-1:0] state_t;

   // The encoding is visible on the stage output, so the values are fixed.
   localparam state_t c_st_idle = 3'd0;
   localparam state_t c_st_if   = 3'd1;
   localparam state_t c_st_id   = 3'd2;
   localparam state_t c_st_exe  = 3'd3;
   localparam state_t c_st_mem  = 3'd4;
   localparam state_t c_st_wb   = 3'd5;
   localparam state_t c_st_halt = 3'd6;

   // True for the states in which an instruction is in flight.
   function automatic logic is_active_stage(input state_t s);
      return (s >= c_st_if) && (s <= c_st_wb);
   endfunction

endpackage
`default_nettype wire

// File: rtl/stage_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : stage_sequencer_if                                     |
// | Description : Handshake and bus bundle between the stage sequencer   |
// |               and the pipeline stages.                               |
// | Ports       : master - sequencer side (drives valids, bus regs)      |
// |               slave  - datapath side (drives overs, cancel, buses)   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface stage_sequencer_if #(
   parameter int ID_EXE_W  = cpu_pkg::ID_EXE_W,
   parameter int EXE_MEM_W = cpu_pkg::EXE_MEM_W
);

   logic                 IF_over;
   logic                 ID_over;
   logic                 EXE_over;
   logic                 MEM_over;
   logic                 WB_over;
   logic                 cancel;
   logic                 halt_req;
   logic [ID_EXE_W-1:0]  ID_EXE_bus;
   logic [EXE_MEM_W-1:0] EXE_MEM_bus;

   logic                 IF_valid;
   logic                 ID_valid;
   logic                 EXE_valid;
   logic                 MEM_valid;
   logic                 WB_valid;
   logic [ID_EXE_W-1:0]  ID_EXE_bus_r;
   logic [EXE_MEM_W-1:0] EXE_MEM_bus_r;

   modport master (
      input  IF_over, ID_over, EXE_over, MEM_over, WB_over,
      input  cancel, halt_req, ID_EXE_bus, EXE_MEM_bus,
      output IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid,
      output ID_EXE_bus_r, EXE_MEM_bus_r
   );

   modport slave (
      output IF_over, ID_over, EXE_over, MEM_over, WB_over,
      output cancel, halt_req, ID_EXE_bus, EXE_MEM_bus,
      input  IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid,
      input  ID_EXE_bus_r, EXE_MEM_bus_r
   );

endinterface
`default_nettype wire

// File: rtl/stage_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : stage_watchdog                                         |
// | Description : Counts cycles spent in one pipeline stage and raises a |
// |               sticky error once the limit is reached.                |
// | Ports       : clk, reset       - clock, async active-high reset      |
// |               state_changed    - sequencer leaves its state this edge|
// |               active           - sequencer is in IF..WB              |
// |               err              - sticky stall error                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module stage_watchdog #(
   parameter int WATCHDOG_CYCLES = 255
) (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic state_changed,
   input  wire logic active,
   output logic      err
);

   generate
      if (WATCHDOG_CYCLES > 0) begin : g_wd_on
         localparam int c_cnt_w = $clog2(WATCHDOG_CYCLES + 1);
         localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(WATCHDOG_CYCLES);
         localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

         logic [c_cnt_w-1:0] r_cnt;
         logic               r_err;
         logic               w_hold;

         // Counting only continues while the sequencer stays put in a live stage.
         assign w_hold = active && !state_changed;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_cnt <= '0;
               r_err <= 1'b0;
            end else begin
               if (!w_hold) begin
                  r_cnt <= '0;
               end else if (r_cnt != c_limit) begin
                  r_cnt <= r_cnt + c_one;
               end
               // Flag on the same edge the counter lands on the limit.
               if (w_hold && (r_cnt == (c_limit - c_one))) begin
                  r_err <= 1'b1;
               end
            end
         end

         assign err = r_err;
      end else begin : g_wd_off
         logic w_unused;
         assign w_unused = &{1'b0, clk, reset, state_changed, active};
         assign err      = 1'b0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : stage_sequencer                                        |
// | Description : Central controller of the multi-cycle CPU. Walks one   |
// |               instruction through IF/ID/EXE/MEM/WB, owns the ID->EXE |
// |               and EXE->MEM bus registers, handles cancel and halt,   |
// |               counts retired instructions and watches for stalls.    |
// | Ports       : clk, reset    - clock, async active-high reset         |
// |               bus (master)  - stage overs/valids, cancel, halt_req,  |
// |                               input buses and registered buses       |
// |               stage         - current state encoding                 |
// |               halted        - high while in HALT                     |
// |               inst_retired  - one-cycle pulse per retirement         |
// |               retire_count  - retired instruction count (wraps)      |
// |               watchdog_err  - sticky stall error                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module stage_sequencer #(
   parameter int ID_EXE_W        = cpu_pkg::ID_EXE_W,
   parameter int EXE_MEM_W       = cpu_pkg::EXE_MEM_W,
   parameter int WATCHDOG_CYCLES = 255
) (
   input  wire logic         clk,
   input  wire logic         reset,
   stage_sequencer_if.master bus,
   output logic [2:0]        stage,
   output logic              halted,
   output logic              inst_retired,
   output logic [31:0]       retire_count,
   output logic              watchdog_err
);

   import cpu_pkg::*;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ID_EXE_W-1:0]  r_id_exe_bus;
   logic [EXE_MEM_W-1:0] r_exe_mem_bus;
   logic [31:0]          r_retire_count;
   logic                 r_inst_retired;
   logic                 w_retire;
   logic                 w_cap_id_exe;
   logic                 w_cap_exe_mem;
   logic                 w_state_changed;
   logic                 w_active;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // cancel is checked before the stage's own over so a flush always wins.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: w_state_nxt = c_st_if;
         c_st_if: begin
            if (bus.cancel)       w_state_nxt = c_st_if;
            else if (bus.IF_over) w_state_nxt = c_st_id;
         end
         c_st_id: begin
            if (bus.cancel)       w_state_nxt = c_st_if;
            else if (bus.ID_over) w_state_nxt = c_st_exe;
         end
         c_st_exe: begin
            if (bus.cancel)        w_state_nxt = c_st_if;
            else if (bus.EXE_over) w_state_nxt = c_st_mem;
         end
         c_st_mem: begin
            if (bus.cancel)        w_state_nxt = c_st_if;
            else if (bus.MEM_over) w_state_nxt = c_st_wb;
         end
         c_st_wb: begin
            if (bus.cancel)       w_state_nxt = c_st_if;
            else if (bus.WB_over) w_state_nxt = bus.halt_req ? c_st_halt : c_st_if;
         end
         c_st_halt: begin
            if (!bus.halt_req) w_state_nxt = c_st_if;
         end
         default: w_state_nxt = c_st_idle;
      endcase
   end

   always_comb begin
      bus.IF_valid  = (r_state == c_st_if);
      bus.ID_valid  = (r_state == c_st_id);
      bus.EXE_valid = (r_state == c_st_exe);
      bus.MEM_valid = (r_state == c_st_mem);
      bus.WB_valid  = (r_state == c_st_wb);
      halted        = (r_state == c_st_halt);
      stage         = r_state;
   end

   // ------------------------------------------------ bus regs and retire
   assign w_retire      = (r_state == c_st_wb)  && bus.WB_over  && !bus.cancel;
   assign w_cap_id_exe  = (r_state == c_st_id)  && bus.ID_over  && !bus.cancel;
   assign w_cap_exe_mem = (r_state == c_st_exe) && bus.EXE_over && !bus.cancel;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_id_exe_bus   <= '0;
         r_exe_mem_bus  <= '0;
         r_retire_count <= 32'd0;
         r_inst_retired <= 1'b0;
      end else begin
         if (w_cap_id_exe) begin
            r_id_exe_bus <= bus.ID_EXE_bus;
         end
         if (w_cap_exe_mem) begin
            r_exe_mem_bus <= bus.EXE_MEM_bus;
         end
         r_inst_retired <= w_retire;
         if (w_retire) begin
            r_retire_count <= r_retire_count + 32'd1;
         end
      end
   end

   assign bus.ID_EXE_bus_r  = r_id_exe_bus;
   assign bus.EXE_MEM_bus_r = r_exe_mem_bus;
   assign inst_retired      = r_inst_retired;
   assign retire_count      = r_retire_count;

   // ------------------------------------------------------------ watchdog
   assign w_state_changed = (w_state_nxt != r_state);
   assign w_active        = is_active_stage(r_state);

   stage_watchdog #(
      .WATCHDOG_CYCLES (WATCHDOG_CYCLES)
   ) u_watchdog (
      .clk           (clk),
      .reset         (reset),
      .state_changed (w_state_changed),
      .active        (w_active),
      .err           (watchdog_err)
   );

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_stage_sequencer                                     |
// | Description : Directed self-checking bench for stage_sequencer.      |
// | Ports       : none                                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_stage_sequencer;

   localparam logic [149:0] c_id_a = {6'h2A, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'hABCD};
   localparam logic [149:0] c_id_b = {6'h15, 128'hFFFF_0000_1111_2222_3333_4444_5555_6666, 16'h1234};
   localparam logic [105:0] c_em_a = {10'h155, 96'hDEAD_BEEF_0000_1111_2222_3333};
   localparam logic [105:0] c_em_b = {10'h0AA, 96'h0BAD_F00D_CAFE_4444_5555_6666};

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  stage;
   logic        halted;
   logic        inst_retired;
   logic [31:0] retire_count;
   logic        watchdog_err;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   stage_sequencer_if #(.ID_EXE_W(150), .EXE_MEM_W(106)) sif ();

   stage_sequencer #(
      .ID_EXE_W        (150),
      .EXE_MEM_W       (106),
      .WATCHDOG_CYCLES (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (sif.master),
      .stage        (stage),
      .halted       (halted),
      .inst_retired (inst_retired),
      .retire_count (retire_count),
      .watchdog_err (watchdog_err)
   );

   task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Valids packed as {IF, ID, EXE, MEM, WB}.
   function automatic logic [4:0] valids();
      return {sif.IF_valid, sif.ID_valid, sif.EXE_valid, sif.MEM_valid, sif.WB_valid};
   endfunction

   task automatic set_overs(input logic [4:0] v);
      {sif.IF_over, sif.ID_over, sif.EXE_over, sif.MEM_over, sif.WB_over} = v;
   endtask

   // Advance n active edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset           = 1'b1;
      set_overs(5'b00000);
      sif.cancel      = 1'b0;
      sif.halt_req    = 1'b0;
      sif.ID_EXE_bus  = '0;
      sif.EXE_MEM_bus = '0;
      step(2);

      // Reset state
      check("rst_stage", stage, 0);
      check("rst_valids", valids(), 0);
      check("rst_flags", {halted, inst_retired, watchdog_err}, 0);
      check("rst_count", retire_count, 0);
      check("rst_buses", {sif.ID_EXE_bus_r, sif.EXE_MEM_bus_r}, 0);

      // Back-to-back instructions with every over asserted
      set_overs(5'b11111);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         check("seq_valids", valids(), 5'b10000 >> i);
         check("seq_stage", stage, i + 1);
      end
      step(1);
      check("seq_retire_pulse", inst_retired, 1);
      check("seq_retire_count1", retire_count, 1);
      check("seq_back_to_if", valids(), 5'b10000);
      step(10);
      check("seq_retire_count3", retire_count, 3);

      // Bus capture and stray overs (now in IF)
      set_overs(5'b10000);
      step(1);                       // -> ID
      sif.ID_EXE_bus = c_id_a;
      set_overs(5'b01000);
      step(1);                       // -> EXE, capture
      check("idexe_capture", sif.ID_EXE_bus_r, c_id_a);
      sif.ID_EXE_bus = c_id_b;       // stray ID_over stays high in EXE
      step(1);
      check("idexe_hold", sif.ID_EXE_bus_r, c_id_a);
      check("stray_over_stage", stage, 3);
      sif.EXE_MEM_bus = c_em_a;
      set_overs(5'b00100);
      step(1);                       // -> MEM, capture
      check("exemem_capture", sif.EXE_MEM_bus_r, c_em_a);

      // Cancel in MEM alongside MEM_over
      sif.EXE_MEM_bus = c_em_b;
      set_overs(5'b00110);
      sif.cancel = 1'b1;
      step(1);
      check("cancel_stage", stage, 1);
      check("cancel_no_retire", inst_retired, 0);
      check("cancel_count", retire_count, 3);
      check("cancel_exemem_hold", sif.EXE_MEM_bus_r, c_em_a);
      sif.cancel = 1'b0;

      // Halt after retirement
      set_overs(5'b11111);
      step(4);                       // ID, EXE, MEM, WB
      check("halt_pre_wb", stage, 5);
      sif.halt_req = 1'b1;
      step(1);
      check("halt_enter", {halted, valids(), stage}, 9'b1_00000_110);
      check("halt_retire", {inst_retired, retire_count}, {1'b1, 32'd4});
      sif.cancel = 1'b1;             // must be ignored in HALT
      for (int i = 0; i < 9; i++) begin
         step(1);
         check("halt_hold", {halted, valids(), stage}, 9'b1_00000_110);
      end
      sif.cancel   = 1'b0;
      sif.halt_req = 1'b0;
      step(1);
      check("halt_exit", {halted, valids()}, 6'b0_10000);

      // Watchdog with a stalled EXE
      check("wd_clear", watchdog_err, 0);
      set_overs(5'b11011);
      step(2);                       // ID, EXE
      check("wd_in_exe", stage, 3);
      step(3);
      check("wd_early", watchdog_err, 0);
      step(1);
      check("wd_fire", watchdog_err, 1);
      set_overs(5'b11111);
      step(1);
      check("wd_sticky_mem", {watchdog_err, stage}, {1'b1, 3'd4});
      step(6);
      check("wd_sticky_late", watchdog_err, 1);
      reset = 1'b1;
      #1;
      check("wd_reset", watchdog_err, 0);

      // Retire counter wrap
      reset = 1'b0;
      step(1);
      check("wrap_in_if", stage, 1);
      force dut.r_retire_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_retire_count;
      check("wrap_preset", retire_count, 32'hFFFF_FFFF);
      step(5);
      check("wrap_zero", {inst_retired, retire_count}, {1'b1, 32'd0});
      step(5);
      check("wrap_next", retire_count, 1);

      // Asynchronous reset in the middle of EXE
      step(2);
      check("mid_exe_stage", stage, 3);
      check("mid_exe_bus", sif.ID_EXE_bus_r, c_id_b);
      #2;
      reset = 1'b1;
      #1;
      check("async_stage_valids", {stage, valids()}, 0);
      check("async_buses", {sif.ID_EXE_bus_r, sif.EXE_MEM_bus_r}, 0);
      check("async_count", retire_count, 0);
      check("async_flags", {halted, inst_retired, watchdog_err}, 0);
      reset = 1'b0;
      step(1);
      check("post_reset_if", valids(), 5'b10000);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
